// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the five-stage MIPS pipeline hazard logic.
//   - MemtoReg writeback-source encodings (WB_*)
//   - forwarding mux select encodings (FWD_*)
//   - multiply-occupancy FSM state type
//   - fwdSel(): forward select for one source register
// ---------------------------------------------------------------------------
package pipe_pkg;

    // Writeback source carried by MemtoReg in the E/M stages
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_LO  = 2'b10;
    localparam logic [1:0] WB_HI  = 2'b11;

    // Execute-stage operand select; 2'b11 is never produced
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef enum logic {
        MULT_IDLE = 1'b0,
        MULT_BUSY = 1'b1
    } mult_state_t;

    // The memory stage holds the younger result, so it beats writeback.
    // Register 0 is hard-wired to zero and is never forwarded.
    function automatic logic [1:0] fwdSel(
        input logic [4:0] src,
        input logic       regWriteM,
        input logic [4:0] writeRegM,
        input logic       regWriteW,
        input logic [4:0] writeRegW
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (src != 5'd0 && regWriteM && writeRegM == src) begin
            sel = FWD_M;
        end else if (src != 5'd0 && regWriteW && writeRegW == src) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_unit_if
// Hazard handshake between the execute stage and the hazard unit.
//   Execute -> hazard : RsE, RtE, WriteRegE, MultStartE, MultDoneE
//   Hazard -> pipeline: ForwardAE, ForwardBE, FlushE, StallF, StallD, StallE
// modport master : the execute stage side
// modport slave  : the hazard unit side
// ---------------------------------------------------------------------------
interface hazard_unit_if;

    logic [4:0] RsE;
    logic [4:0] RtE;
    logic [4:0] WriteRegE;
    logic       MultStartE;
    logic       MultDoneE;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       FlushE;
    logic       StallF;
    logic       StallD;
    logic       StallE;

    modport master (
        output RsE, RtE, WriteRegE, MultStartE, MultDoneE,
        input  ForwardAE, ForwardBE, FlushE, StallF, StallD, StallE
    );

    modport slave (
        input  RsE, RtE, WriteRegE, MultStartE, MultDoneE,
        output ForwardAE, ForwardBE, FlushE, StallF, StallD, StallE
    );

endinterface

// File: rtl/hazard_unit_mult_tracker.sv
// ---------------------------------------------------------------------------
// mult_tracker
// Tracks occupancy of the iterative multiplier and watches for a hang.
//   clk, rst    : clock, synchronous active-high reset
//   i_start     : multiply instruction sitting in execute
//   i_done      : multiplier reports completion
//   o_mhold     : hold the pipeline for the in-flight multiply
//   o_timeout   : multiply abandoned this cycle (flush + restart)
//   o_busy      : FSM in BUSY
//   o_err       : sticky flag, a multiply has ever timed out
// ---------------------------------------------------------------------------
module mult_tracker
    import pipe_pkg::*;
#(
    parameter int MULT_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_done,
    output logic o_mhold,
    output logic o_timeout,
    output logic o_busy,
    output logic o_err
);

    localparam int CW = (MULT_TIMEOUT > 1) ? $clog2(MULT_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MULT_TIMEOUT - 1);

    mult_state_t   r_state;
    mult_state_t   w_nextState;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          w_timeout;
    logic          w_mhold;

    // State register plus the BUSY-cycle counter and sticky error flag.
    // The counter is re-armed to zero every IDLE cycle so a fresh multiply
    // always starts counting from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MULT_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == MULT_IDLE) begin
                r_cnt <= '0;
            end else if (!i_done && !w_timeout) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Next-state: completion and timeout both return to IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            MULT_IDLE: if (i_start && !i_done) w_nextState = MULT_BUSY;
            MULT_BUSY: if (i_done || w_timeout) w_nextState = MULT_IDLE;
            default:   w_nextState = MULT_IDLE;
        endcase
    end

    // Outputs. A done arriving in the final allowed cycle wins over the
    // watchdog, so the timeout is qualified with !i_done here; that keeps
    // the error, flush and stall all quiet in that cycle.
    always_comb begin
        w_timeout = (r_state == MULT_BUSY) && (r_cnt == LAST) && !i_done;
        w_mhold   = i_start && !i_done && !w_timeout;
    end

    assign o_timeout = w_timeout;
    assign o_mhold   = w_mhold;
    assign o_busy    = (r_state == MULT_BUSY);
    assign o_err     = r_err;

endmodule

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Hazard controller for the five-stage MIPS pipeline: operand forwarding,
// load-use / branch stalls, multiply occupancy hold and a stall counter.
//   clk, rst          : clock, synchronous active-high reset
//   hz (slave)        : execute-stage hazard handshake (see hazard_unit_if)
//   RsD, RtD, BranchD : decode-stage sources and branch flag
//   RegWriteE, MemtoRegE            : execute-stage write info
//   WriteRegM, RegWriteM, MemtoRegM : memory-stage write info
//   WriteRegW, RegWriteW            : writeback-stage write info
//   ForwardAD/BD      : forward ALUOutM into the decode comparator
//   MultBusy, MultErr : multiply FSM busy / sticky timeout flag
//   StallCount        : saturating count of stalled cycles since reset
// ---------------------------------------------------------------------------
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int MULT_TIMEOUT = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    hazard_unit_if.slave     hz,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic             BranchD,
    input  logic             RegWriteE,
    input  logic [1:0]       MemtoRegE,
    input  logic [4:0]       WriteRegM,
    input  logic             RegWriteM,
    input  logic [1:0]       MemtoRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteW,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             MultBusy,
    output logic             MultErr,
    output logic [CNT_W-1:0] StallCount
);

    logic             w_lwStall;
    logic             w_brStall;
    logic             w_mhold;
    logic             w_timeout;
    logic             w_stall;
    logic [CNT_W-1:0] r_stallCount;

    mult_tracker #(
        .MULT_TIMEOUT(MULT_TIMEOUT)
    ) u_multTracker (
        .clk      (clk),
        .rst      (rst),
        .i_start  (hz.MultStartE),
        .i_done   (hz.MultDoneE),
        .o_mhold  (w_mhold),
        .o_timeout(w_timeout),
        .o_busy   (MultBusy),
        .o_err    (MultErr)
    );

    assign hz.ForwardAE = fwdSel(hz.RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
    assign hz.ForwardBE = fwdSel(hz.RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);

    assign ForwardAD = (RsD != 5'd0) && RegWriteM && (WriteRegM == RsD);
    assign ForwardBD = (RtD != 5'd0) && RegWriteM && (WriteRegM == RtD);

    // A branch resolves in decode, so it must wait for any producer still
    // in execute, and for a load still in memory (its data is not ready
    // for the decode comparator until writeback).
    always_comb begin
        w_lwStall = (MemtoRegE == WB_MEM) && ((hz.RtE == RsD) || (hz.RtE == RtD));
        w_brStall = BranchD &&
                    ((RegWriteE && (hz.WriteRegE != 5'd0) &&
                      ((hz.WriteRegE == RsD) || (hz.WriteRegE == RtD))) ||
                     ((MemtoRegM == WB_MEM) && (WriteRegM != 5'd0) &&
                      ((WriteRegM == RsD) || (WriteRegM == RtD))));
        w_stall   = w_lwStall | w_brStall | w_mhold | w_timeout;
    end

    // A held multiply must not be bubbled by a load/branch flush; only the
    // watchdog is allowed to kill it.
    assign hz.StallF = w_stall;
    assign hz.StallD = w_stall;
    assign hz.StallE = w_mhold;
    assign hz.FlushE = ((w_lwStall | w_brStall) & ~w_mhold) | w_timeout;

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCount <= '0;
        end else if (w_stall && (r_stallCount != {CNT_W{1'b1}})) begin
            r_stallCount <= r_stallCount + CNT_W'(1);
        end
    end

    assign StallCount = r_stallCount;

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage MIPS core. It is the responder side of the execute stage's hazard interface: it consumes `RsE`/`RtE`/`WriteRegE`, `MultStartE` and `MultDoneE`, and returns `ForwardAE`/`ForwardBE`, `FlushE` and the stall signals. It adds a registered multiply-occupancy FSM with a timeout watchdog and a saturating stall-cycle counter. The execute stage honours the new `StallE` input by holding its pipeline register.

## Interface

**Parameters**
- `MULT_TIMEOUT`, default 64: maximum BUSY cycles before the multiply is abandoned.
- `CNT_W`, default 16: width of the stall counter.

**Ports**
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Synchronous, active-high; one clock.
- `RsD`, `RtD`, in, 5 each: decode-stage source registers.
- `BranchD`, in, 1: branch in decode.
- `RsE`, `RtE`, `WriteRegE`, in, 5 each: execute-stage register numbers.
- `RegWriteE`, in, 1: execute-stage register write.
- `MemtoRegE`, in, 2: execute-stage writeback source.
- `MultStartE`, `MultDoneE`, in, 1 each: multiply in execute / multiplier completed.
- `WriteRegM`, in, 5; `RegWriteM`, in, 1; `MemtoRegM`, in, 2: memory stage.
- `WriteRegW`, in, 5; `RegWriteW`, in, 1: writeback stage.
- `StallF`, `StallD`, `StallE`, out, 1 each: hold the corresponding pipeline register.
- `FlushE`, out, 1: bubble the execute register.
- `ForwardAD`, `ForwardBD`, out, 1 each: forward `ALUOutM` to the decode comparator.
- `ForwardAE`, `ForwardBE`, out, 2 each: execute operand select.
- `MultBusy`, out, 1: FSM in BUSY.
- `MultErr`, out, 1: sticky timeout flag.
- `StallCount`, out, `CNT_W`: stall cycles since reset.

## Operation

**MemtoReg encoding**
- 2'b00: ALU result.
- 2'b01: memory load.
- 2'b10: LO.
- 2'b11: HI.

**Execute forwarding**
- `ForwardAE` = 2'b10 if `RsE != 0 && RegWriteM && WriteRegM == RsE`.
- Else `ForwardAE` = 2'b01 if `RsE != 0 && RegWriteW && WriteRegW == RsE`.
- Else `ForwardAE` = 2'b00.
- `ForwardBE` follows the same rule using `RtE`.
- The M stage has priority over the W stage. 2'b11 is never driven.

**Decode forwarding**
- `ForwardAD` = `RsD != 0 && RegWriteM && WriteRegM == RsD`.
- `ForwardBD` uses the same rule with `RtD`.

**Hazard terms**
- `lwstall` = `MemtoRegE == 2'b01 && (RtE == RsD || RtE == RtD)`.
- `brstall` = `BranchD && ((RegWriteE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD)) || (MemtoRegM == 2'b01 && WriteRegM != 0 && (WriteRegM == RsD || WriteRegM == RtD)))`.
- `mhold` = `MultStartE && !MultDoneE && !timeout`, where `timeout` = (state == BUSY && `cnt == MULT_TIMEOUT-1`).

**Outputs**
- `StallF` = `StallD` = `lwstall | brstall | mhold | timeout`.
- `StallE` = `mhold`.
- `FlushE` = `(lwstall | brstall) & !mhold`, OR `timeout`.
- `mhold` suppresses the load/branch flush so the in-flight multiply is never killed.

**Multiply FSM** (states IDLE, BUSY)
- IDLE → BUSY when `MultStartE && !MultDoneE`; `cnt` is cleared to 0.
- BUSY, `MultDoneE`: go to IDLE.
- BUSY, `timeout` without `MultDoneE`: set `MultErr` and go to IDLE. `FlushE` is high that cycle, which bubbles the multiply.
- BUSY otherwise: stay in BUSY and increment `cnt`.
- `MultDoneE` and `timeout` in the same cycle: done wins, no error, no flush.

**Stall counter**
- `StallCount` increments on every cycle with `StallF` high.
- Saturates at all-ones.

## Timing

- Forward, stall and flush outputs are combinational from the inputs and the registered state. Zero latency.
- FSM, `cnt`, `MultErr` and `StallCount` update on the rising edge of `clk`.
- `MultBusy` rises one cycle after `MultStartE` is first seen. Stalls begin in that same first cycle, through `mhold`.
- Release: the cycle in which `MultDoneE` is high has all stalls low, so the next instruction enters E at that edge.
- Maximum hold is `MULT_TIMEOUT + 1` cycles.
- While `rst` is high, all registered outputs clear on the next edge:
  - state = IDLE, `cnt` = 0, `MultErr` = 0, `StallCount` = 0, `MultBusy` = 0.
- Reset asserted mid-multiply returns the FSM to IDLE with no error recorded.

## Structure

- Shared package `pipe_pkg` holds:
  - MemtoReg encoding constants (`WB_ALU`, `WB_MEM`, `WB_LO`, `WB_HI`);
  - forward-select constants (`FWD_REG` = 2'b00, `FWD_W` = 2'b01, `FWD_M` = 2'b10);
  - the FSM state enum.
- One sub-module, `mult_tracker`, contains the FSM, `cnt`, `MultErr`, `timeout` and `mhold`.
- The top level contains the forwarding, stall/flush logic and `StallCount`.

## Test plan

- Forwarding: `RsE` = 5, `RegWriteM` = 1, `WriteRegM` = 5, `RegWriteW` = 1, `WriteRegW` = 5 → `ForwardAE` = 2'b10. With `RsE` = 0 and the same M/W values → `ForwardAE` = 2'b00.
- Load-use: `MemtoRegE` = 2'b01, `RtE` = 8, `RsD` = 8 → `StallF` = `StallD` = `FlushE` = 1, `StallE` = 0. `StallCount` advances by 1.
- Branch: `BranchD` = 1, `RegWriteE` = 1, `WriteRegE` = 3, `RtD` = 3 → stall and flush. Next cycle `WriteRegM` = 3, `RegWriteM` = 1, `MemtoRegM` = 2'b00 → no stall, `ForwardBD` = 1.
- Multiply: `MultStartE` high for 10 cycles with `MultDoneE` pulsed in cycle 10 → `StallE` = 1 in cycles 1–9, 0 in cycle 10. `MultBusy` = 1 in cycles 2–10. `FlushE` stays 0 throughout, even with `lwstall` forced.
- Timeout: `MULT_TIMEOUT` = 4, `MultStartE` held, no done → `FlushE` = 1 and `StallE` = 0 in the cycle where `cnt` = 3. `MultErr` = 1 thereafter. Repeat with `MultDoneE` in that same cycle → `MultErr` stays 0.
- Reset mid-BUSY: assert `rst` for one cycle → state IDLE, `MultBusy` = 0, `MultErr` = 0, `StallCount` = 0 on the next edge.
